jk_mod_counter: RTL and testbench

- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit register whose bits follow JK semantics, with built-in modulo-N up/down counting modes.
- Used as the general counter/state register in later lab designs: decade counters, dividers, and sequencers that preset states bit by bit.
- Fully synchronous to one clock; no asynchronous set/clear paths.

---
 rtl/jk_mod_counter.sv | 111 +++++++++++
 tb/tb_jk_mod_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/jk_mod_counter.sv
// WIDTH-bit register with per-bit JK updates and modulo-MODULUS up/down counting.
// Optional synchronous preload (ports ld, d) is enabled by defining JK_PRELOAD_EN.
module jk_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
`ifdef JK_PRELOAD_EN
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeUp   = 2'b01,
    ModeDown = 2'b10,
    ModeJk   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] jk_next;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    jk_next = q_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      unique case ({j[i], k[i]})
        2'b00:   jk_next[i] = q_q[i];
        2'b01:   jk_next[i] = 1'b0;
        2'b10:   jk_next[i] = 1'b1;
        default: jk_next[i] = ~q_q[i];
      endcase
    end
  end

  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (en) begin
`ifdef JK_PRELOAD_EN
      if (ld) begin
        q_d = d;
      end else begin
`endif
        unique case (mode_sel)
          ModeHold: q_d = q_q;
          ModeUp: begin
            if (q_q == MaxVal) begin
              q_d   = '0;
              ovf_d = 1'b1;
            end else if (q_q > MaxVal) begin
              // Out-of-range values (left behind by JK mode) snap back without a wrap pulse.
              q_d = '0;
            end else begin
              q_d = q_q + WIDTH'(1);
            end
          end
          ModeDown: begin
            if (q_q == '0) begin
              q_d   = MaxVal;
              ovf_d = 1'b1;
            end else if (q_q > MaxVal) begin
              q_d = MaxVal;
            end else begin
              q_d = q_q - WIDTH'(1);
            end
          end
          default: q_d = jk_next;
        endcase
`ifdef JK_PRELOAD_EN
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    tc = 1'b0;
    if (mode_sel == ModeUp && q_q == MaxVal) tc = 1'b1;
    if (mode_sel == ModeDown && q_q == '0)   tc = 1'b1;
  end

  assign q   = q_q;
  assign qb  = ~q_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: directed scenarios plus randomized traffic
// against an arithmetic reference model. Define JK_PRELOAD_EN to cover preload.
module tb_jk_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [1:0]   mode;
  logic [W-1:0] j, k, q, qb;
  logic         tc, ovf;
  logic         ld;
  logic [W-1:0] d;

  int n_checks = 0;
  int n_errors = 0;
  int qm  = 0;  // model register value
  int ovm = 0;  // model wrap pulse

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .j    (j),
    .k    (k),
`ifdef JK_PRELOAD_EN
    .ld   (ld),
    .d    (d),
`endif
    .q    (q),
    .qb   (qb),
    .tc   (tc),
    .ovf  (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference next-state computed straight from the behavioural rules.
  task automatic model_next(input logic r, input logic e, input logic [1:0] m,
                            input logic [W-1:0] jj, input logic [W-1:0] kk,
                            input logic l, input logic [W-1:0] dd,
                            output int nq, output int nov);
    nq  = qm;
    nov = 0;
    if (r) begin
      nq = 0;
    end else if (e) begin
      if (l) nq = int'(dd);
      else if (m == 2'd1) begin
        if (qm == M - 1) begin nq = 0; nov = 1; end
        else if (qm > M - 1) nq = 0;
        else nq = qm + 1;
      end else if (m == 2'd2) begin
        if (qm == 0) begin nq = M - 1; nov = 1; end
        else if (qm > M - 1) nq = M - 1;
        else nq = qm - 1;
      end else if (m == 2'd3) begin
        nq = 0;
        for (int b = 0; b < W; b++) begin
          int bit_v;
          bit_v = (qm >> b) & 1;
          if (jj[b] && kk[b]) bit_v = 1 - bit_v;
          else if (jj[b]) bit_v = 1;
          else if (kk[b]) bit_v = 0;
          nq += bit_v << b;
        end
      end
    end
  endtask

  // Drive one cycle, check combinational outputs before the edge and state after it.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [W-1:0] jj, input logic [W-1:0] kk,
                      input logic l, input logic [W-1:0] dd);
    int nq, nov, tce;
    rst = r; en = e; mode = m; j = jj; k = kk;
`ifdef JK_PRELOAD_EN
    ld = l; d = dd;
`else
    ld = 1'b0; d = '0;
`endif
    #1;
    tce = ((m == 2'd1 && qm == M - 1) || (m == 2'd2 && qm == 0)) ? 1 : 0;
    check("tc", 32'(tc), 32'(tce));
    model_next(r, e, m, jj, kk, ld, d, nq, nov);
    @(posedge clk);
    #1;
    qm  = nq;
    ovm = nov;
    check("q", 32'(q), 32'(qm));
    check("qb", 32'(qb), 32'((~qm) & ((1 << W) - 1)));
    check("ovf", 32'(ovf), 32'(ovm));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b01; j = '0; k = '0; ld = 1'b0; d = '0;
    @(posedge clk);
    #1;
    check("rst_q", 32'(q), 32'd0);
    step(1, 1, 2'b01, 0, 0, 0, 0);
    check("rst_qb", 32'(qb), 32'hF);
    check("rst_ovf", 32'(ovf), 32'd0);
    step(0, 1, 2'b01, 0, 0, 0, 0);
    check("rel_q", 32'(q), 32'd1);

    // Up count from 0 through the wrap.
    step(1, 1, 2'b01, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 2'b01, 0, 0, 0, 0);
    check("up_wrap_q", 32'(q), 32'd0);
    check("up_wrap_ovf", 32'(ovf), 32'd1);

    // Down from 0 wraps to M-1.
    step(0, 1, 2'b10, 0, 0, 0, 0);
    check("dn_wrap_q", 32'(q), 32'd9);
    check("dn_wrap_ovf", 32'(ovf), 32'd1);
    step(0, 1, 2'b10, 0, 0, 0, 0);
    check("dn_q", 32'(q), 32'd8);
    check("dn_ovf", 32'(ovf), 32'd0);

    // JK mode: preset 0101, then j=1100 k=1010 (toggle, set, clear, hold) -> 1101.
    step(1, 1, 2'b00, 0, 0, 0, 0);
    step(0, 1, 2'b11, 4'b0101, 4'b1010, 0, 0);
    step(0, 1, 2'b11, 4'b1100, 4'b1010, 0, 0);
    check("jk_q", 32'(q), 32'd13);
    step(0, 1, 2'b01, 0, 0, 0, 0);
    check("oor_up_q", 32'(q), 32'd0);
    check("oor_up_ovf", 32'(ovf), 32'd0);
    step(0, 1, 2'b11, 4'b1100, 4'b0011, 0, 0);
    check("jk12_q", 32'(q), 32'd12);
    step(0, 1, 2'b10, 0, 0, 0, 0);
    check("oor_dn_q", 32'(q), 32'd9);
    check("oor_dn_ovf", 32'(ovf), 32'd0);

    // Enable low holds mid-count, then reset at 7.
    step(1, 1, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 2'b01, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b01, 0, 0, 0, 0);
    check("en0_q", 32'(q), 32'd6);
    step(0, 1, 2'b01, 0, 0, 0, 0);
    step(1, 1, 2'b01, 0, 0, 0, 0);
    check("mid_rst_q", 32'(q), 32'd0);

`ifdef JK_PRELOAD_EN
    step(0, 1, 2'b10, 0, 0, 1, 4'd8);
    check("ld_q", 32'(q), 32'd8);
    step(0, 1, 2'b01, 0, 0, 0, 0);
    step(0, 1, 2'b01, 0, 0, 0, 0);
    check("ld_wrap_ovf", 32'(ovf), 32'd1);
    step(1, 1, 2'b01, 0, 0, 1, 4'd5);
    check("ld_rst_q", 32'(q), 32'd0);
`endif

    // Randomized traffic; JK mode frequently leaves out-of-range values.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
           ($urandom_range(0, 9) == 0), W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
